// File: rtl/decode_issue_queue.sv
// RV32I decoder feeding a small in-order queue. The head issues to the RS or the LSB once
// a ROB tag is free and its operands are resolved through the regfile, the ROB or the previous issue.
`ifndef OPLEN
`define OPLEN 6
`define NOP   6'd0
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define SLTI  6'd20
`define SLTIU 6'd21
`define XORI  6'd22
`define ORI   6'd23
`define ANDI  6'd24
`define SLLI  6'd25
`define SRLI  6'd26
`define SRAI  6'd27
`define ADD   6'd28
`define SUB   6'd29
`define SLL   6'd30
`define SLT   6'd31
`define SLTU  6'd32
`define XOR   6'd33
`define SRL   6'd34
`define SRA   6'd35
`define OR    6'd36
`define AND   6'd37
`endif
`ifndef ROBNOTRENAME
`define ROBNOTRENAME 4'b0000
`endif

module decode_issue_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int ROB_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  if_valid_i,
    input  logic [31:0]           if_instr_i,
    input  logic [31:0]           if_pc_i,
    output logic                  if_ready_o,
    input  logic                  flush_i,
    input  logic                  rob_full_i,
    input  logic [ROB_WIDTH-1:0]  rob_free_tag_i,
    output logic                  rob_alloc_o,
    input  logic                  rs_full_i,
    input  logic                  lsb_full_i,
    output logic [4:0]            reg_rs1_index_o,
    output logic [4:0]            reg_rs2_index_o,
    input  logic                  reg_rs1_renamed_i,
    input  logic [ROB_WIDTH-1:0]  reg_rs1_rename_i,
    input  logic [31:0]           reg_rs1_value_i,
    input  logic                  reg_rs2_renamed_i,
    input  logic [ROB_WIDTH-1:0]  reg_rs2_rename_i,
    input  logic [31:0]           reg_rs2_value_i,
    output logic [ROB_WIDTH-1:0]  rob_rs1_index_o,
    output logic [ROB_WIDTH-1:0]  rob_rs2_index_o,
    input  logic                  rob_rs1_ready_i,
    input  logic [31:0]           rob_rs1_value_i,
    input  logic                  rob_rs2_ready_i,
    input  logic [31:0]           rob_rs2_value_i,
    output logic                  issue_valid_o,
    output logic                  issue_to_lsb_o,
    output logic [`OPLEN-1:0]     issue_op_o,
    output logic [31:0]           issue_pc_o,
    output logic [31:0]           issue_imm_o,
    output logic [31:0]           issue_rs1_value_o,
    output logic [ROB_WIDTH-1:0]  issue_rs1_rename_o,
    output logic [31:0]           issue_rs2_value_o,
    output logic [ROB_WIDTH-1:0]  issue_rs2_rename_o,
    output logic [ROB_WIDTH-1:0]  issue_rd_rename_o,
    output logic [4:0]            issue_rd_index_o,
    output logic                  issue_has_rd_o,
    output logic                  illegal_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ROB_WIDTH-1:0] NO_RENAME = ROB_WIDTH'(`ROBNOTRENAME);

    typedef struct packed {
        logic [`OPLEN-1:0] op;
        logic              lsb;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              use_rs1;
        logic              use_rs2;
        logic              has_rd;
    } entry_t;

    typedef struct packed {
        logic [31:0]          val;
        logic [ROB_WIDTH-1:0] ren;
    } opnd_t;

    typedef struct packed {
        logic                 lsb;
        logic [`OPLEN-1:0]    op;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [31:0]          rs1_val;
        logic [ROB_WIDTH-1:0] rs1_ren;
        logic [31:0]          rs2_val;
        logic [ROB_WIDTH-1:0] rs2_ren;
        logic [ROB_WIDTH-1:0] rd_ren;
        logic [4:0]           rd_idx;
        logic                 has_rd;
    } issue_t;

    // First match wins: x0/unused, previous-issue bypass, committed regfile value, ROB value, tag.
    function automatic opnd_t resolve_opnd(
        input logic                 use_src,
        input logic [4:0]           idx,
        input logic                 byp_hit,
        input logic [ROB_WIDTH-1:0] byp_tag,
        input logic                 reg_renamed,
        input logic [ROB_WIDTH-1:0] reg_rename,
        input logic [31:0]          reg_value,
        input logic                 rob_ready,
        input logic [31:0]          rob_value
    );
        opnd_t r;
        r.val = 32'd0;
        r.ren = NO_RENAME;
        if (!use_src || (idx == 5'd0)) begin
            r.val = 32'd0;
            r.ren = NO_RENAME;
        end else if (byp_hit) begin
            r.val = 32'd0;
            r.ren = byp_tag;
        end else if (!reg_renamed) begin
            r.val = reg_value;
            r.ren = NO_RENAME;
        end else if (rob_ready) begin
            r.val = rob_value;
            r.ren = NO_RENAME;
        end else begin
            r.val = 32'd0;
            r.ren = reg_rename;
        end
        return r;
    endfunction

    entry_t             q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               iss_valid_q, iss_valid_d;
    logic               illegal_q, illegal_d;
    issue_t             iss_q, iss_d;

    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    entry_t      dec_s;
    logic        dec_legal_s;
    logic        fmt_rd_s;

    assign f3_s    = if_instr_i[14:12];
    assign f7_s    = if_instr_i[31:25];
    assign imm_i_s = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b_s = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7], if_instr_i[30:25], if_instr_i[11:8], 1'b0};
    assign imm_u_s = {if_instr_i[31:12], 12'd0};
    assign imm_j_s = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12], if_instr_i[20], if_instr_i[30:21], 1'b0};

    // Decode the fetched word into a queue entry and flag unsupported encodings.
    always_comb begin
        dec_legal_s = 1'b1;
        fmt_rd_s    = 1'b0;
        dec_s       = '0;
        dec_s.op    = `NOP;
        dec_s.pc    = if_pc_i;
        case (if_instr_i[6:0])
            7'b0110111: begin dec_s.op = `LUI;   dec_s.imm = imm_u_s; fmt_rd_s = 1'b1; end
            7'b0010111: begin dec_s.op = `AUIPC; dec_s.imm = imm_u_s; fmt_rd_s = 1'b1; end
            7'b1101111: begin dec_s.op = `JAL;   dec_s.imm = imm_j_s; fmt_rd_s = 1'b1; end
            7'b1100111: begin
                dec_s.op = `JALR; dec_s.imm = imm_i_s; dec_s.use_rs1 = 1'b1; fmt_rd_s = 1'b1;
                if (f3_s == 3'b000) begin
                    dec_legal_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            7'b1100011: begin
                dec_s.imm = imm_b_s; dec_s.use_rs1 = 1'b1; dec_s.use_rs2 = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.op = `BEQ;
                    3'b001:  dec_s.op = `BNE;
                    3'b100:  dec_s.op = `BLT;
                    3'b101:  dec_s.op = `BGE;
                    3'b110:  dec_s.op = `BLTU;
                    3'b111:  dec_s.op = `BGEU;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec_s.imm = imm_i_s; dec_s.lsb = 1'b1; dec_s.use_rs1 = 1'b1; fmt_rd_s = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.op = `LB;
                    3'b001:  dec_s.op = `LH;
                    3'b010:  dec_s.op = `LW;
                    3'b100:  dec_s.op = `LBU;
                    3'b101:  dec_s.op = `LHU;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            7'b0100011: begin
                dec_s.imm = imm_s_s; dec_s.lsb = 1'b1; dec_s.use_rs1 = 1'b1; dec_s.use_rs2 = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.op = `SB;
                    3'b001:  dec_s.op = `SH;
                    3'b010:  dec_s.op = `SW;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_s.imm = imm_i_s; dec_s.use_rs1 = 1'b1; fmt_rd_s = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.op = `ADDI;
                    3'b010:  dec_s.op = `SLTI;
                    3'b011:  dec_s.op = `SLTIU;
                    3'b100:  dec_s.op = `XORI;
                    3'b110:  dec_s.op = `ORI;
                    3'b111:  dec_s.op = `ANDI;
                    3'b001: begin
                        if (f7_s == 7'b0000000) begin
                            dec_s.op = `SLLI;
                        end else begin
                            dec_legal_s = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (f7_s == 7'b0000000) begin
                            dec_s.op = `SRLI;
                        end else if (f7_s == 7'b0100000) begin
                            dec_s.op = `SRAI;
                        end else begin
                            dec_legal_s = 1'b0;
                        end
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            7'b0110011: begin
                dec_s.use_rs1 = 1'b1; dec_s.use_rs2 = 1'b1; fmt_rd_s = 1'b1;
                case ({f7_s, f3_s})
                    10'b0000000_000: dec_s.op = `ADD;
                    10'b0100000_000: dec_s.op = `SUB;
                    10'b0000000_001: dec_s.op = `SLL;
                    10'b0000000_010: dec_s.op = `SLT;
                    10'b0000000_011: dec_s.op = `SLTU;
                    10'b0000000_100: dec_s.op = `XOR;
                    10'b0000000_101: dec_s.op = `SRL;
                    10'b0100000_101: dec_s.op = `SRA;
                    10'b0000000_110: dec_s.op = `OR;
                    10'b0000000_111: dec_s.op = `AND;
                    default:         dec_legal_s = 1'b0;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
        dec_s.rs1    = dec_s.use_rs1 ? if_instr_i[19:15] : 5'd0;
        dec_s.rs2    = dec_s.use_rs2 ? if_instr_i[24:20] : 5'd0;
        dec_s.rd     = fmt_rd_s ? if_instr_i[11:7] : 5'd0;
        dec_s.has_rd = fmt_rd_s && (if_instr_i[11:7] != 5'd0);
    end

    entry_t head_s;
    opnd_t  opnd1_s, opnd2_s;
    logic   byp1_s, byp2_s, unit_busy_s, issue_s, enq_try_s, enq_s, not_empty_s;

    assign head_s      = q_mem[head_q];
    assign not_empty_s = (count_q != '0);
    assign if_ready_o  = (count_q < CNT_W'(QUEUE_DEPTH));
    assign byp1_s      = iss_valid_q && iss_q.has_rd && (iss_q.rd_idx == head_s.rs1);
    assign byp2_s      = iss_valid_q && iss_q.has_rd && (iss_q.rd_idx == head_s.rs2);
    assign opnd1_s     = resolve_opnd(head_s.use_rs1, head_s.rs1, byp1_s, iss_q.rd_ren, reg_rs1_renamed_i,
                                      reg_rs1_rename_i, reg_rs1_value_i, rob_rs1_ready_i, rob_rs1_value_i);
    assign opnd2_s     = resolve_opnd(head_s.use_rs2, head_s.rs2, byp2_s, iss_q.rd_ren, reg_rs2_renamed_i,
                                      reg_rs2_rename_i, reg_rs2_value_i, rob_rs2_ready_i, rob_rs2_value_i);
    assign unit_busy_s = head_s.lsb ? lsb_full_i : rs_full_i;
    assign issue_s     = not_empty_s && rdy_i && !flush_i && !rob_full_i && !unit_busy_s;
    assign enq_try_s   = if_valid_i && if_ready_o && rdy_i && !flush_i;
    assign enq_s       = enq_try_s && dec_legal_s;

    assign reg_rs1_index_o = not_empty_s ? head_s.rs1 : 5'd0;
    assign reg_rs2_index_o = not_empty_s ? head_s.rs2 : 5'd0;
    assign rob_rs1_index_o = reg_rs1_rename_i;
    assign rob_rs2_index_o = reg_rs2_rename_i;

    // Next-state: flush beats everything, rdy low freezes, otherwise enqueue/issue.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        iss_valid_d = iss_valid_q;
        illegal_d   = illegal_q;
        iss_d       = iss_q;
        if (flush_i) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            iss_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (rdy_i) begin
            illegal_d   = enq_try_s && !dec_legal_s;
            iss_valid_d = issue_s;
            if (enq_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (issue_s) begin
                head_d        = head_q + PTR_W'(1);
                iss_d.lsb     = head_s.lsb;
                iss_d.op      = head_s.op;
                iss_d.pc      = head_s.pc;
                iss_d.imm     = head_s.imm;
                iss_d.rs1_val = opnd1_s.val;
                iss_d.rs1_ren = opnd1_s.ren;
                iss_d.rs2_val = opnd2_s.val;
                iss_d.rs2_ren = opnd2_s.ren;
                iss_d.rd_ren  = rob_free_tag_i;
                iss_d.rd_idx  = head_s.rd;
                iss_d.has_rd  = head_s.has_rd;
            end else begin
                head_d = head_q;
            end
            case ({enq_s, issue_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end else begin
            iss_valid_d = iss_valid_q;
        end
    end

    // Control and issue-output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            illegal_q     <= 1'b0;
            iss_q         <= '0;
            iss_q.rs1_ren <= NO_RENAME;
            iss_q.rs2_ren <= NO_RENAME;
            iss_q.rd_ren  <= NO_RENAME;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            illegal_q   <= illegal_d;
            iss_q       <= iss_d;
        end
    end

    // Queue storage, written at the tail on an accepted legal instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (enq_s) begin
            q_mem[tail_q] <= dec_s;
        end else begin
            q_mem[tail_q] <= q_mem[tail_q];
        end
    end

    assign issue_valid_o      = iss_valid_q;
    assign rob_alloc_o        = iss_valid_q;
    assign illegal_o          = illegal_q;
    assign issue_to_lsb_o     = iss_q.lsb;
    assign issue_op_o         = iss_q.op;
    assign issue_pc_o         = iss_q.pc;
    assign issue_imm_o        = iss_q.imm;
    assign issue_rs1_value_o  = iss_q.rs1_val;
    assign issue_rs1_rename_o = iss_q.rs1_ren;
    assign issue_rs2_value_o  = iss_q.rs2_val;
    assign issue_rs2_rename_o = iss_q.rs2_ren;
    assign issue_rd_rename_o  = iss_q.rd_ren;
    assign issue_rd_index_o   = iss_q.rd_idx;
    assign issue_has_rd_o     = iss_q.has_rd;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: hand-computed vectors checked with immediate assertions.
module tb_decode_issue_queue;

    localparam logic [5:0] OP_LUI = 6'd1, OP_BEQ = 6'd5, OP_LW = 6'd13, OP_SW = 6'd18,
                           OP_ADDI = 6'd19, OP_ADD = 6'd28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy, if_valid, flush, rob_full, rs_full, lsb_full;
    logic [31:0] if_instr, if_pc;
    logic [3:0]  rob_free_tag;
    logic        reg_rs1_renamed, reg_rs2_renamed, rob_rs1_ready, rob_rs2_ready;
    logic [3:0]  reg_rs1_rename, reg_rs2_rename;
    logic [31:0] reg_rs1_value, reg_rs2_value, rob_rs1_value, rob_rs2_value;
    logic        if_ready, rob_alloc, issue_valid, issue_to_lsb, issue_has_rd, illegal;
    logic [4:0]  reg_rs1_index, reg_rs2_index, issue_rd_index;
    logic [3:0]  rob_rs1_index, rob_rs2_index, issue_rs1_rename, issue_rs2_rename, issue_rd_rename;
    logic [5:0]  issue_op;
    logic [31:0] issue_pc, issue_imm, issue_rs1_value, issue_rs2_value;

    int n_tests = 0;
    int n_fail  = 0;

    decode_issue_queue #(.QUEUE_DEPTH(4), .ROB_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
        .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc), .if_ready_o(if_ready),
        .flush_i(flush), .rob_full_i(rob_full), .rob_free_tag_i(rob_free_tag), .rob_alloc_o(rob_alloc),
        .rs_full_i(rs_full), .lsb_full_i(lsb_full),
        .reg_rs1_index_o(reg_rs1_index), .reg_rs2_index_o(reg_rs2_index),
        .reg_rs1_renamed_i(reg_rs1_renamed), .reg_rs1_rename_i(reg_rs1_rename), .reg_rs1_value_i(reg_rs1_value),
        .reg_rs2_renamed_i(reg_rs2_renamed), .reg_rs2_rename_i(reg_rs2_rename), .reg_rs2_value_i(reg_rs2_value),
        .rob_rs1_index_o(rob_rs1_index), .rob_rs2_index_o(rob_rs2_index),
        .rob_rs1_ready_i(rob_rs1_ready), .rob_rs1_value_i(rob_rs1_value),
        .rob_rs2_ready_i(rob_rs2_ready), .rob_rs2_value_i(rob_rs2_value),
        .issue_valid_o(issue_valid), .issue_to_lsb_o(issue_to_lsb), .issue_op_o(issue_op),
        .issue_pc_o(issue_pc), .issue_imm_o(issue_imm),
        .issue_rs1_value_o(issue_rs1_value), .issue_rs1_rename_o(issue_rs1_rename),
        .issue_rs2_value_o(issue_rs2_value), .issue_rs2_rename_o(issue_rs2_rename),
        .issue_rd_rename_o(issue_rd_rename), .issue_rd_index_o(issue_rd_index),
        .issue_has_rd_o(issue_has_rd), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push one instruction into an empty queue, then check it on the issue cycle.
    task automatic run_one(input string tag, input logic [31:0] instr, input logic [5:0] eop,
                           input logic [31:0] eimm, input logic elsb, input logic ehas, input logic [4:0] erd);
        if_valid = 1'b1; if_instr = instr; if_pc = 32'h0000_0200;
        tick();
        if_valid = 1'b0;
        tick();
        check({tag, ".valid"}, {31'd0, issue_valid}, 32'd1);
        check({tag, ".op"}, {26'd0, issue_op}, {26'd0, eop});
        check({tag, ".imm"}, issue_imm, eimm);
        check({tag, ".lsb"}, {31'd0, issue_to_lsb}, {31'd0, elsb});
        check({tag, ".has_rd"}, {31'd0, issue_has_rd}, {31'd0, ehas});
        if (ehas) check({tag, ".rd"}, {27'd0, issue_rd_index}, {27'd0, erd});
        tick();
    endtask

    logic [31:0] bad_instr [3];

    initial begin
        rdy = 1'b1; if_valid = 1'b0; flush = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        if_instr = 32'd0; if_pc = 32'd0; rob_free_tag = 4'd0;
        reg_rs1_renamed = 1'b0; reg_rs2_renamed = 1'b0; rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;
        reg_rs1_rename = 4'd0; reg_rs2_rename = 4'd0;
        reg_rs1_value = 32'd0; reg_rs2_value = 32'd0; rob_rs1_value = 32'd0; rob_rs2_value = 32'd0;
        bad_instr[0] = 32'hFFFF_FFFF; bad_instr[1] = 32'h0000_0073; bad_instr[2] = 32'h4000_9093;

        // Reset state
        tick();
        check("rst.issue_valid", {31'd0, issue_valid}, 32'd0);
        check("rst.if_ready", {31'd0, if_ready}, 32'd1);
        check("rst.rob_alloc", {31'd0, rob_alloc}, 32'd0);
        check("rst.illegal", {31'd0, illegal}, 32'd0);
        check("rst.rd_rename", {28'd0, issue_rd_rename}, 32'd0);
        rst = 1'b0;
        tick();

        // addi x1,x0,5 with tag 3: issues two edges after the handshake; x0 ignores regfile value
        rob_free_tag = 4'd3; reg_rs1_value = 32'h0000_DEAD;
        if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h0000_0100;
        tick();
        if_valid = 1'b0;
        check("addi.not_yet", {31'd0, issue_valid}, 32'd0);
        tick();
        check("addi.valid", {31'd0, issue_valid}, 32'd1);
        check("addi.alloc", {31'd0, rob_alloc}, 32'd1);
        check("addi.lsb", {31'd0, issue_to_lsb}, 32'd0);
        check("addi.op", {26'd0, issue_op}, {26'd0, OP_ADDI});
        check("addi.imm", issue_imm, 32'd5);
        check("addi.pc", issue_pc, 32'h0000_0100);
        check("addi.rs1_val", issue_rs1_value, 32'd0);
        check("addi.rs1_ren", {28'd0, issue_rs1_rename}, 32'd0);
        check("addi.rd", {27'd0, issue_rd_index}, 32'd1);
        check("addi.rd_ren", {28'd0, issue_rd_rename}, 32'd3);
        check("addi.has_rd", {31'd0, issue_has_rd}, 32'd1);
        tick();
        check("addi.one_shot", {31'd0, issue_valid}, 32'd0);

        // addi then lw x2,8(x1) back-to-back: lw picks up tag 3 through the bypass
        reg_rs1_value = 32'h0000_1234;
        if_valid = 1'b1; if_instr = 32'h0050_0093;
        tick();
        if_instr = 32'h0080_A103;
        tick();
        if_valid = 1'b0; rob_free_tag = 4'd4;
        check("byp.addi_rd_ren", {28'd0, issue_rd_rename}, 32'd3);
        tick();
        check("byp.valid", {31'd0, issue_valid}, 32'd1);
        check("byp.lsb", {31'd0, issue_to_lsb}, 32'd1);
        check("byp.op", {26'd0, issue_op}, {26'd0, OP_LW});
        check("byp.imm", issue_imm, 32'd8);
        check("byp.rs1_ren", {28'd0, issue_rs1_rename}, 32'd3);
        check("byp.rs1_val", issue_rs1_value, 32'd0);
        check("byp.rd", {27'd0, issue_rd_index}, 32'd2);
        check("byp.rd_ren", {28'd0, issue_rd_rename}, 32'd4);
        tick();

        // add x3,x1,x2: rs1 from regfile, rs2 from a ready ROB entry
        reg_rs1_renamed = 1'b0; reg_rs1_value = 32'h11;
        reg_rs2_renamed = 1'b1; reg_rs2_rename = 4'd5; rob_rs2_ready = 1'b1; rob_rs2_value = 32'h22;
        rob_free_tag = 4'd6;
        if_valid = 1'b1; if_instr = 32'h0020_81B3;
        tick();
        if_valid = 1'b0;
        check("add.rs1_idx", {27'd0, reg_rs1_index}, 32'd1);
        check("add.rs2_idx", {27'd0, reg_rs2_index}, 32'd2);
        check("add.rob_rs2_idx", {28'd0, rob_rs2_index}, 32'd5);
        tick();
        check("add.op", {26'd0, issue_op}, {26'd0, OP_ADD});
        check("add.rs1_val", issue_rs1_value, 32'h11);
        check("add.rs2_val", issue_rs2_value, 32'h22);
        check("add.rs2_ren", {28'd0, issue_rs2_rename}, 32'd0);
        check("add.rd_ren", {28'd0, issue_rd_rename}, 32'd6);
        tick();

        // sw x2,12(x1): rs1 from ROB, rs2 still pending as tag 5
        reg_rs1_renamed = 1'b1; reg_rs1_rename = 4'd7; rob_rs1_ready = 1'b1; rob_rs1_value = 32'hAAAA;
        rob_rs2_ready = 1'b0;
        if_valid = 1'b1; if_instr = 32'h0020_A623;
        tick();
        if_valid = 1'b0;
        tick();
        check("sw.lsb", {31'd0, issue_to_lsb}, 32'd1);
        check("sw.op", {26'd0, issue_op}, {26'd0, OP_SW});
        check("sw.imm", issue_imm, 32'd12);
        check("sw.rs1_val", issue_rs1_value, 32'hAAAA);
        check("sw.rs1_ren", {28'd0, issue_rs1_rename}, 32'd0);
        check("sw.rs2_val", issue_rs2_value, 32'd0);
        check("sw.rs2_ren", {28'd0, issue_rs2_rename}, 32'd5);
        check("sw.has_rd", {31'd0, issue_has_rd}, 32'd0);
        tick();
        reg_rs1_renamed = 1'b0; reg_rs2_renamed = 1'b0; rob_rs1_ready = 1'b0;

        // Immediate formats: negative I, B, U
        run_one("addim1", 32'hFFF0_0293, OP_ADDI, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd5);
        run_one("beq", 32'hFE00_0EE3, OP_BEQ, 32'hFFFF_FFFC, 1'b0, 1'b0, 5'd0);
        run_one("lui", 32'h1234_5337, OP_LUI, 32'h1234_5000, 1'b0, 1'b1, 5'd6);

        // Backpressure: five pushes with rs_full, only four accepted, then four issues in order
        rs_full = 1'b1; if_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if_instr = 32'h0050_0013 | (k << 7);
            check($sformatf("full.if_ready%0d", k), {31'd0, if_ready}, (k <= 4) ? 32'd1 : 32'd0);
            tick();
        end
        if_valid = 1'b0; rs_full = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("drain.valid%0d", k), {31'd0, issue_valid}, 32'd1);
            check($sformatf("drain.rd%0d", k), {27'd0, issue_rd_index}, k);
        end
        tick();
        check("drain.done", {31'd0, issue_valid}, 32'd0);
        check("drain.if_ready", {31'd0, if_ready}, 32'd1);

        // Flush with three queued entries
        rs_full = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093;
        for (int k = 0; k < 3; k++) tick();
        if_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; rs_full = 1'b0;
        check("flush.if_ready", {31'd0, if_ready}, 32'd1);
        check("flush.valid0", {31'd0, issue_valid}, 32'd0);
        tick();
        check("flush.valid1", {31'd0, issue_valid}, 32'd0);
        tick();
        check("flush.valid2", {31'd0, issue_valid}, 32'd0);

        // Illegal encodings: one-cycle pulse, nothing queued or issued
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_instr = bad_instr[k];
            tick();
            if_valid = 1'b0;
            check($sformatf("ill%0d.pulse", k), {31'd0, illegal}, 32'd1);
            tick();
            check($sformatf("ill%0d.clear", k), {31'd0, illegal}, 32'd0);
            check($sformatf("ill%0d.no_issue", k), {31'd0, issue_valid}, 32'd0);
        end

        // rob_full then rdy low hold queued work; outputs hold while rdy is low
        rob_full = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093;
        tick();
        if_valid = 1'b0;
        tick();
        check("robfull.hold", {31'd0, issue_valid}, 32'd0);
        rob_full = 1'b0; rdy = 1'b0;
        tick();
        check("rdy0.no_issue", {31'd0, issue_valid}, 32'd0);
        rdy = 1'b1;
        tick();
        check("rdy1.issue", {31'd0, issue_valid}, 32'd1);
        rdy = 1'b0;
        tick();
        check("rdy0.out_hold", {31'd0, issue_valid}, 32'd1);
        rdy = 1'b1;
        tick();
        check("rdy1.cleared", {31'd0, issue_valid}, 32'd0);

        // Reset mid-stream clears outputs at once and discards the queue
        rs_full = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093;
        tick();
        if_instr = 32'h0050_0113;
        tick();
        if_valid = 1'b0; rs_full = 1'b0; rob_free_tag = 4'd9;
        tick();
        check("mid.issue", {31'd0, issue_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid.rst_valid", {31'd0, issue_valid}, 32'd0);
        check("mid.rst_alloc", {31'd0, rob_alloc}, 32'd0);
        check("mid.rst_rd_ren", {28'd0, issue_rd_rename}, 32'd0);
        check("mid.rst_if_ready", {31'd0, if_ready}, 32'd1);
        #1 rst = 1'b0;
        tick();
        check("mid.empty0", {31'd0, issue_valid}, 32'd0);
        check("mid.no_illegal", {31'd0, illegal}, 32'd0);
        tick();
        check("mid.empty1", {31'd0, issue_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
